uart_time_cmd: RTL and testbench

Framed UART command decoder for the RTC path: sits between the UART receiver and the PCF8563 I2C write controller. Parses byte-stream frames (header, command, date/time payload, optional checksum, trailer) with an inter-byte timeout. Sequences the resulting time and/or date write requests against the controller's `set_done` handshake. Reports accept/error per frame.

---
 rtl/rtc_cmd_pkg.sv | 45 ++++
 rtl/uart_time_cmd_if.sv | 27 ++
 rtl/rtc_write_seq.sv | 57 +++++
 rtl/uart_time_cmd.sv | 219 +++++++++++++++++++++
 tb/tb_uart_time_cmd.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_cmd_pkg.sv
// Shared types and constants for the UART time/date command decoder.
// Optional checksum byte is enabled with the UART_TIME_CMD_CHKSUM_EN macro.
package rtc_cmd_pkg;

  typedef enum logic [2:0] {
    P_HDR,
    P_CMD,
    P_PAY,
`ifdef UART_TIME_CMD_CHKSUM_EN
    P_CHK,
`endif
    P_TRL
  } parse_state_e;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_TIME,
    Q_DATE
  } seq_state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_TRL     = 2'd2;
  localparam logic [1:0] ERR_BUSY    = 2'd3;

  localparam int CMD_TIME_BIT = 0;
  localparam int CMD_DATE_BIT = 1;

  localparam int PAY_BYTES = 7;

  // Byte idx of a 3-byte pattern, idx 0 being the first byte on the wire.
  function automatic logic [7:0] pat_byte(input logic [23:0] pat, input logic [1:0] idx);
    case (idx)
      2'd0:    pat_byte = pat[23:16];
      2'd1:    pat_byte = pat[15:8];
      default: pat_byte = pat[7:0];
    endcase
  endfunction

  // A command must request at least one write and use no reserved bits.
  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    cmd_is_bad = (cmd[7:2] != 6'd0) || (cmd == 8'd0);
  endfunction

endpackage

// File: rtl/uart_time_cmd_if.sv
// Bus between the UART receiver / I2C write controller and the command decoder.
// slave: decoder side; master: the surrounding UART and I2C logic.
interface uart_time_cmd_if;
  logic [7:0]  uart_rx_data;
  logic        uart_data_valid;
  logic        set_done;
  logic        set_time;
  logic [23:0] time_2_set;
  logic        set_date;
  logic [31:0] date_2_set;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;

  modport slave (
    input  uart_rx_data, uart_data_valid, set_done,
    output set_time, time_2_set, set_date, date_2_set, busy,
           frame_ok, frame_err, err_code
  );

  modport master (
    output uart_rx_data, uart_data_valid, set_done,
    input  set_time, time_2_set, set_date, date_2_set, busy,
           frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/rtc_write_seq.sv
// Issues the time and/or date write requests for one accepted frame,
// one at a time, advancing on each set_done pulse from the I2C controller.
module rtc_write_seq
  import rtc_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [1:0] cmd_i,
  input  logic       set_done_i,
  output logic       set_time_o,
  output logic       set_date_o,
  output logic       busy_o
);

  seq_state_e state_q, state_d;
  logic       date_pend_q, date_pend_d;

  // State register and the remembered "date follows time" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Q_IDLE;
      date_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      date_pend_q <= date_pend_d;
    end
  end

  // Next state and request levels; set_done while idle is ignored.
  always_comb begin
    state_d     = state_q;
    date_pend_d = date_pend_q;
    set_time_o  = 1'b0;
    set_date_o  = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      Q_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          date_pend_d = cmd_i[CMD_DATE_BIT];
          state_d     = cmd_i[CMD_TIME_BIT] ? Q_TIME : Q_DATE;
        end
      end
      Q_TIME: begin
        set_time_o = 1'b1;
        if (set_done_i) state_d = date_pend_q ? Q_DATE : Q_IDLE;
      end
      Q_DATE: begin
        set_date_o = 1'b1;
        if (set_done_i) state_d = Q_IDLE;
      end
      default: state_d = Q_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_time_cmd.sv
// Framed UART command decoder for the RTC path: parses
// header/CMD/payload/[CHK]/trailer frames, latches the time/date words and
// hands them to rtc_write_seq. Define UART_TIME_CMD_CHKSUM_EN to require an
// XOR checksum byte after the payload.
module uart_time_cmd
  import rtc_cmd_pkg::*;
#(
  parameter logic [23:0] HDR_PATTERN = 24'hF0F1F2,
  parameter logic [23:0] TRL_PATTERN = 24'hF2F1F0,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  uart_time_cmd_if.slave  bus
);

  localparam int TO_LIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int TO_W   = (TO_LIM < 2) ? 1 : $clog2(TO_LIM + 1);

  parse_state_e      state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        pay_cnt_q, pay_cnt_d;
  logic [55:0]       stage_q, stage_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [23:0]       time_q, time_d;
  logic [31:0]       date_q, date_d;
`ifdef UART_TIME_CMD_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       counting;
  logic       timeout_hit;
  logic       seq_start;
  logic       seq_busy;
  logic       seq_set_time;
  logic       seq_set_date;

  assign rx_byte     = bus.uart_rx_data;
  assign rx_vld      = bus.uart_data_valid;
  assign counting    = !((state_q == P_HDR) && (idx_q == 2'd0));
  assign timeout_hit = (TIMEOUT_CYC != 0) && counting && (to_cnt_q == TO_W'(TO_LIM));

  // Control state, timeout counter and all externally visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= P_HDR;
      idx_q       <= 2'd0;
      pay_cnt_q   <= 3'd0;
      cmd_q       <= 2'd0;
      to_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      time_q      <= 24'd0;
      date_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pay_cnt_q   <= pay_cnt_d;
      cmd_q       <= cmd_d;
      to_cnt_q    <= to_cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      time_q      <= time_d;
      date_q      <= date_d;
    end
  end

  // Payload staging (and running checksum) only matter once a frame completes.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
`ifdef UART_TIME_CMD_CHKSUM_EN
    chk_q   <= chk_d;
`endif
  end

  // Parser next state: one byte per valid strobe, timeout when idle mid-frame.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pay_cnt_d   = pay_cnt_q;
    stage_d     = stage_q;
    cmd_d       = cmd_q;
`ifdef UART_TIME_CMD_CHKSUM_EN
    chk_d       = chk_q;
`endif
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    time_d      = time_q;
    date_d      = date_q;
    seq_start   = 1'b0;
    to_cnt_d    = '0;
    if ((TIMEOUT_CYC != 0) && !rx_vld && counting && !timeout_hit)
      to_cnt_d = to_cnt_q + 1'b1;

    if (rx_vld) begin
      case (state_q)
        P_HDR: begin
          if (rx_byte == pat_byte(HDR_PATTERN, idx_q)) begin
            if (idx_q == 2'd2) begin
              state_d = P_CMD;
              idx_d   = 2'd0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            // A stray first header byte may itself start the real header.
            idx_d = (rx_byte == pat_byte(HDR_PATTERN, 2'd0)) ? 2'd1 : 2'd0;
          end
        end
        P_CMD: begin
          if (cmd_is_bad(rx_byte)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CMD;
            state_d     = P_HDR;
            idx_d       = 2'd0;
          end else begin
            cmd_d     = rx_byte[1:0];
            pay_cnt_d = 3'd0;
            state_d   = P_PAY;
`ifdef UART_TIME_CMD_CHKSUM_EN
            chk_d     = rx_byte;
`endif
          end
        end
        P_PAY: begin
          stage_d = {stage_q[47:0], rx_byte};
`ifdef UART_TIME_CMD_CHKSUM_EN
          chk_d   = chk_q ^ rx_byte;
`endif
          if (pay_cnt_q == 3'(PAY_BYTES - 1)) begin
            idx_d = 2'd0;
`ifdef UART_TIME_CMD_CHKSUM_EN
            state_d = P_CHK;
`else
            state_d = P_TRL;
`endif
          end else begin
            pay_cnt_d = pay_cnt_q + 3'd1;
          end
        end
`ifdef UART_TIME_CMD_CHKSUM_EN
        P_CHK: begin
          if (rx_byte == chk_q) begin
            state_d = P_TRL;
            idx_d   = 2'd0;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TRL;
            state_d     = P_HDR;
            idx_d       = 2'd0;
          end
        end
`endif
        P_TRL: begin
          if (rx_byte != pat_byte(TRL_PATTERN, idx_q)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TRL;
            state_d     = P_HDR;
            idx_d       = 2'd0;
          end else if (idx_q == 2'd2) begin
            state_d = P_HDR;
            idx_d   = 2'd0;
            // Busy sampled this cycle, so a same-cycle final set_done still rejects.
            if (seq_busy) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_BUSY;
            end else begin
              frame_ok_d = 1'b1;
              date_d     = stage_q[55:24];
              time_d     = stage_q[23:0];
              seq_start  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = P_HDR;
          idx_d   = 2'd0;
        end
      endcase
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = P_HDR;
      idx_d       = 2'd0;
    end
  end

  rtc_write_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (seq_start),
    .cmd_i      (cmd_q),
    .set_done_i (bus.set_done),
    .set_time_o (seq_set_time),
    .set_date_o (seq_set_date),
    .busy_o     (seq_busy)
  );

  assign bus.set_time   = seq_set_time;
  assign bus.set_date   = seq_set_date;
  assign bus.busy       = seq_busy;
  assign bus.time_2_set = time_q;
  assign bus.date_2_set = date_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_uart_time_cmd.sv
// Testbench for uart_time_cmd: directed steps plus randomized frames checked
// against a frame-level reference model and a queue of pending write requests.
module tb_uart_time_cmd;

  logic clk = 1'b0;
  logic rst;

  uart_time_cmd_if bus();

  uart_time_cmd #(.TIMEOUT_CYC(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  frm[$];
  int          pend[$];          // outstanding write requests: 0 = time, 1 = date
  logic [23:0] exp_time;
  logic [31:0] exp_date;
  logic [7:0]  hdr_b [3] = '{8'hF0, 8'hF1, 8'hF2};
  logic [7:0]  trl_b [3] = '{8'hF2, 8'hF1, 8'hF0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_set_time"}, bus.set_time, (pend.size() > 0) ? (pend[0] == 0) : 1'b0);
    chk({tag, "_set_date"}, bus.set_date, (pend.size() > 0) ? (pend[0] == 1) : 1'b0);
    chk({tag, "_busy"}, bus.busy, pend.size() > 0);
  endtask

  task automatic pulse_done();
    bus.set_done = 1'b1;
    tick();
    bus.set_done = 1'b0;
    if (pend.size() > 0) void'(pend.pop_front());
    chk_seq("done");
  endtask

  task automatic drain();
    while (pend.size() > 0) begin
      repeat ($urandom_range(0, 3)) tick();
      pulse_done();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uart_rx_data    = b;
    bus.uart_data_valid = 1'b1;
    tick();
    bus.uart_data_valid = 1'b0;
  endtask

  task automatic build(input logic [7:0] cmd, input logic [55:0] pay);
    logic [7:0] x;
    frm.delete();
    for (int i = 0; i < 3; i++) frm.push_back(hdr_b[i]);
    frm.push_back(cmd);
    x = cmd;
    for (int i = 6; i >= 0; i--) begin
      frm.push_back(pay[i*8 +: 8]);
      x ^= pay[i*8 +: 8];
    end
`ifdef UART_TIME_CMD_CHKSUM_EN
    frm.push_back(x);
`endif
    for (int i = 0; i < 3; i++) frm.push_back(trl_b[i]);
  endtask

  // Decide the frame outcome from the framing rules, then send up to the
  // deciding byte and compare everything visible afterwards.
  task automatic run_frame(input int gap_max, input bit done_on_last);
    int         code;
    int         pos;
    int         trl0;
    logic [7:0] c;
    logic [7:0] x;
    code = -1;
    pos  = 0;
    trl0 = 11;
    c    = frm[3];
    if (c[7:2] != 6'd0 || c == 8'd0) begin
      code = 1;
      pos  = 3;
    end else begin
`ifdef UART_TIME_CMD_CHKSUM_EN
      x = c;
      for (int i = 4; i <= 10; i++) x ^= frm[i];
      if (frm[11] !== x) begin
        code = 2;
        pos  = 11;
      end
      trl0 = 12;
`else
      x = 8'd0;
`endif
      for (int t = 0; t < 3; t++)
        if (code < 0 && frm[trl0+t] !== trl_b[t]) begin
          code = 2;
          pos  = trl0 + t;
        end
      if (code < 0) begin
        pos  = trl0 + 2;
        code = (pend.size() > 0) ? 3 : -1;
      end
    end

    for (int i = 0; i <= pos; i++) begin
      bus.uart_rx_data    = frm[i];
      bus.uart_data_valid = 1'b1;
      if (i == pos) bus.set_done = done_on_last;
      tick();
      bus.uart_data_valid = 1'b0;
      bus.set_done        = 1'b0;
      if (i < pos) begin
        chk("mid_pulses", {bus.frame_ok, bus.frame_err}, 2'b00);
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end

    if (done_on_last && pend.size() > 0) void'(pend.pop_front());
    if (code < 0) begin
      exp_time = {frm[8], frm[9], frm[10]};
      exp_date = {frm[4], frm[5], frm[6], frm[7]};
      if (c[0]) pend.push_back(0);
      if (c[1]) pend.push_back(1);
      chk("frame_ok", bus.frame_ok, 1'b1);
      chk("frame_err", bus.frame_err, 1'b0);
    end else begin
      chk("frame_ok", bus.frame_ok, 1'b0);
      chk("frame_err", bus.frame_err, 1'b1);
      chk("err_code", bus.err_code, code);
    end
    chk("time_2_set", bus.time_2_set, exp_time);
    chk("date_2_set", bus.date_2_set, exp_date);
    chk_seq("post");
    tick();
    chk("pulse_end", {bus.frame_ok, bus.frame_err}, 2'b00);
  endtask

  initial begin
    logic [7:0] c;
    rst                 = 1'b1;
    bus.uart_rx_data    = 8'd0;
    bus.uart_data_valid = 1'b0;
    bus.set_done        = 1'b0;
    exp_time            = 24'd0;
    exp_date            = 32'd0;
    repeat (3) tick();
    chk("rst_outputs", {bus.set_time, bus.set_date, bus.busy, bus.frame_ok,
                        bus.frame_err, bus.err_code}, 7'd0);
    chk("rst_time", bus.time_2_set, 24'd0);
    chk("rst_date", bus.date_2_set, 32'd0);
    rst = 1'b0;
    tick();

    // Reference frame: time then date.
    build(8'h03, 56'h24061506123456);
    run_frame(0, 1'b0);
    chk("tp_date", bus.date_2_set, 32'h24061506);
    chk("tp_time", bus.time_2_set, 24'h123456);
    repeat (4) begin tick(); chk_seq("hold"); end
    pulse_done();
    chk("tp_date_req", bus.set_date, 1'b1);
    pulse_done();
    chk("tp_idle", bus.busy, 1'b0);

    // Date-only command.
    build(8'h02, {$urandom, $urandom});
    run_frame(2, 1'b0);
    chk("date_only_no_time", bus.set_time, 1'b0);
    drain();

    // Header resync after a stray F0.
    send_byte(8'hF0);
    chk("resync_quiet", {bus.frame_ok, bus.frame_err}, 2'b00);
    build(8'h01, {$urandom, $urandom});
    run_frame(1, 1'b0);
    drain();

    // Bad command, bad trailer.
    build(8'h04, {$urandom, $urandom});
    run_frame(1, 1'b0);
    build(8'h03, {$urandom, $urandom});
    frm[frm.size()-1] = 8'h00;
    run_frame(1, 1'b0);

    // Frame while busy, and frame completing on the final set_done.
    build(8'h01, {$urandom, $urandom});
    run_frame(1, 1'b0);
    build(8'h03, {$urandom, $urandom});
    run_frame(1, 1'b0);
    build(8'h02, {$urandom, $urandom});
    run_frame(0, 1'b1);
    chk("same_cycle_done_idle", bus.busy, 1'b0);

    // set_done while idle is ignored.
    pulse_done();

    // Inter-byte timeout after 5 bytes.
    send_byte(8'hF0); send_byte(8'hF1); send_byte(8'hF2);
    send_byte(8'h01); send_byte(8'h12);
    repeat (99) tick();
    chk("timeout_early", bus.frame_err, 1'b0);
    tick();
    chk("timeout_err", bus.frame_err, 1'b1);
    chk("timeout_code", bus.err_code, 2'd0);
    tick();
    chk("timeout_pulse", bus.frame_err, 1'b0);
    build(8'h03, {$urandom, $urandom});
    run_frame(2, 1'b0);
    drain();

`ifdef UART_TIME_CMD_CHKSUM_EN
    build(8'h01, {$urandom, $urandom});
    frm[11] = frm[11] ^ 8'h01;
    run_frame(1, 1'b0);
`endif

    // Randomized frames with occasional faults and pending requests.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
      else                            c = 8'($urandom_range(1, 3));
      build(c, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0)
        frm[frm.size() - 1 - $urandom_range(0, 2)] ^= 8'($urandom_range(1, 255));
      run_frame(3, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) drain();
      else if (pend.size() == 0 && $urandom_range(0, 1) == 0) pulse_done();
    end
    drain();

    // Reset in the middle of a time write.
    build(8'h03, {$urandom, $urandom});
    run_frame(1, 1'b0);
    chk("pre_rst_time_req", bus.set_time, 1'b1);
    rst = 1'b1;
    tick();
    pend.delete();
    exp_time = 24'd0;
    exp_date = 32'd0;
    chk("rst_mid_outputs", {bus.set_time, bus.set_date, bus.busy, bus.frame_ok,
                            bus.frame_err, bus.err_code}, 7'd0);
    chk("rst_mid_time", bus.time_2_set, 24'd0);
    chk("rst_mid_date", bus.date_2_set, 32'd0);
    rst = 1'b0;
    tick();
    build(8'h02, {$urandom, $urandom});
    run_frame(1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
